// File: rtl/snake_key_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snake_key_conditioner: sync/debounce KEY[1:0] into one pending turn req. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module snake_key_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int DROP_W          = 8
) (
  input  logic              clockInp,
  input  logic              resetInp,
  input  logic [1:0]        KEY,
  input  logic              move_tick,
  output logic              turn_valid,
  output logic              turn_right,
  output logic [1:0]        key_level,
  output logic [DROP_W-1:0] drop_count
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] press;
  logic       consume;
  logic       drop_event;

  generate
    for (genvar k = 0; k < 2; k++) begin : g_key
      logic [SYNC_STAGES-1:0] sync;
      logic [CNT_W-1:0]       cnt;
      logic                   level;
      logic                   sampled;

      assign sampled      = ~sync[SYNC_STAGES-1];
      assign key_level[k] = level;
      // Rising edge of the debounced level is the only press event.
      assign press[k]     = sampled & ~level & (cnt == CNT_LAST);

      always_ff @(posedge clockInp) begin
        if (!resetInp) begin
          sync  <= '1;
          cnt   <= '0;
          level <= 1'b0;
        end else begin
          sync <= {sync[SYNC_STAGES-2:0], KEY[k]};
          if (sampled == level) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= ~level;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign consume = move_tick & turn_valid;

  always_comb begin
    drop_event = 1'b0;
    if (press == 2'b11) begin
      drop_event = 1'b1;
    end else if ((press != 2'b00) && turn_valid && !consume) begin
      drop_event = 1'b1;
    end
  end

  always_ff @(posedge clockInp) begin
    if (!resetInp) begin
      turn_valid <= 1'b0;
      turn_right <= 1'b0;
    end else begin
      case (press)
        2'b11: begin
          if (consume) turn_valid <= 1'b0;
        end
        2'b01, 2'b10: begin
          // A fresh press may replace the request being consumed this edge.
          if (!turn_valid || consume) begin
            turn_valid <= 1'b1;
            turn_right <= press[0];
          end
        end
        default: begin
          if (consume) turn_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clockInp) begin
    if (!resetInp) begin
      drop_count <= '0;
    end else if (drop_event && (drop_count != {DROP_W{1'b1}})) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_key_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_snake_key_conditioner: directed + random bench with reference model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_snake_key_conditioner;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int DW   = 8;

  logic          clk;
  logic          rst_n;
  logic [1:0]    keys;
  logic          tick;
  logic          valid;
  logic          right;
  logic [1:0]    level;
  logic [DW-1:0] drops;

  int checks = 0;
  int passes = 0;

  snake_key_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .DROP_W(DW)) dut (
    .clockInp(clk), .resetInp(rst_n), .KEY(keys), .move_tick(tick),
    .turn_valid(valid), .turn_right(right), .key_level(level), .drop_count(drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a key level flips once the last DEB synchronised samples
  // all disagree with it; requests follow the turn-queue rules directly.
  logic [SYNC-1:0] m_pipe [2];
  logic [DEB-1:0]  m_hist [2];
  logic [1:0]      m_level;
  logic            m_valid, m_right;
  int              m_drop;

  always @(posedge clk) begin
    logic [1:0] old_level;
    logic [1:0] pr;
    logic       cons;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pipe[k] = '1;
        m_hist[k] = '0;
      end
      m_level = 2'b00; m_valid = 1'b0; m_right = 1'b0; m_drop = 0;
    end else begin
      old_level = m_level;
      for (int k = 0; k < 2; k++) begin
        m_hist[k] = {m_hist[k][DEB-2:0], ~m_pipe[k][SYNC-1]};
        m_pipe[k] = {m_pipe[k][SYNC-2:0], keys[k]};
        if ((m_hist[k] ^ {DEB{old_level[k]}}) == {DEB{1'b1}}) begin
          m_level[k] = ~old_level[k];
          m_hist[k]  = {DEB{m_level[k]}};
        end
      end
      pr   = m_level & ~old_level;
      cons = tick && m_valid;
      if (pr == 2'b11) begin
        if (m_drop < 255) m_drop++;
        if (cons) m_valid = 1'b0;
      end else if (pr != 2'b00) begin
        if (!m_valid || cons) begin
          m_valid = 1'b1;
          m_right = pr[0];
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end else if (cons) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("model_valid", {31'd0, valid}, {31'd0, m_valid});
      if (m_valid) chk("model_right", {31'd0, right}, {31'd0, m_right});
      chk("model_level", {30'd0, level}, {30'd0, m_level});
      chk("model_drop", {24'd0, drops}, m_drop);
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1; step(1); tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; keys = 2'b11; tick = 1'b0;
    step(3);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_right", {31'd0, right}, 0);
    chk("rst_level", {30'd0, level}, 0);
    chk("rst_drop", {24'd0, drops}, 0);
    rst_n = 1'b1;
    step(2);

    // clean right press, consume, release
    keys = 2'b10; step(5);
    chk("right_early", {31'd0, valid}, 0);
    step(1);
    chk("right_level", {30'd0, level}, 2'b01);
    chk("right_valid", {31'd0, valid}, 1);
    chk("right_dir", {31'd0, right}, 1);
    step(3); pulse_tick();
    chk("right_consumed", {31'd0, valid}, 0);
    step(9);
    keys = 2'b11; step(6);
    chk("release_level", {30'd0, level}, 0);
    chk("release_noreq", {31'd0, valid}, 0);

    // bounce rejection then held left press
    keys = 2'b01; step(3); keys = 2'b11; step(2); keys = 2'b01; step(3); keys = 2'b11; step(8);
    chk("bounce_level", {30'd0, level}, 0);
    chk("bounce_valid", {31'd0, valid}, 0);
    chk("bounce_drop", {24'd0, drops}, 0);
    keys = 2'b01; step(5);
    chk("left_early", {31'd0, valid}, 0);
    step(1);
    chk("left_valid", {31'd0, valid}, 1);
    chk("left_dir", {31'd0, right}, 0);
    pulse_tick(); keys = 2'b11; step(8);

    // overrun
    keys = 2'b10; step(6); keys = 2'b11; step(8);
    keys = 2'b01; step(6);
    chk("overrun_valid", {31'd0, valid}, 1);
    chk("overrun_dir", {31'd0, right}, 1);
    chk("overrun_drop", {24'd0, drops}, 1);
    keys = 2'b11; step(8); pulse_tick();
    chk("overrun_consumed", {31'd0, valid}, 0);

    // simultaneous presses
    keys = 2'b00; step(6);
    chk("simul_level", {30'd0, level}, 2'b11);
    chk("simul_valid", {31'd0, valid}, 0);
    chk("simul_drop", {24'd0, drops}, 2);
    keys = 2'b11; step(8);
    keys = 2'b10; step(6); keys = 2'b11; step(8);
    keys = 2'b00; step(5); pulse_tick();
    chk("simul_tick_valid", {31'd0, valid}, 0);
    chk("simul_tick_drop", {24'd0, drops}, 3);
    keys = 2'b11; step(8);

    // tick/press collision
    keys = 2'b01; step(6); keys = 2'b11; step(8);
    keys = 2'b10; step(5); pulse_tick();
    chk("coll_valid", {31'd0, valid}, 1);
    chk("coll_dir", {31'd0, right}, 1);
    chk("coll_drop", {24'd0, drops}, 3);
    keys = 2'b11; pulse_tick();
    chk("coll_next_tick", {31'd0, valid}, 0);
    step(8);

    // reset mid-debounce with key held
    keys = 2'b10; step(3);
    rst_n = 1'b0; step(1);
    chk("midrst_level", {30'd0, level}, 0);
    chk("midrst_valid", {31'd0, valid}, 0);
    chk("midrst_drop", {24'd0, drops}, 0);
    rst_n = 1'b1; step(5);
    chk("postrst_early", {30'd0, level}, 0);
    step(1);
    chk("postrst_level", {30'd0, level}, 2'b01);
    chk("postrst_valid", {31'd0, valid}, 1);
    pulse_tick(); keys = 2'b11; step(8);

    // randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      int hold;
      keys = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 8);
      for (int j = 0; j < hold; j++) begin
        tick = ($urandom_range(0, 7) == 0);
        step(1);
      end
    end
    tick = 1'b0; keys = 2'b11; step(8);

    // saturation
    for (int i = 0; i < 300; i++) begin
      keys = 2'b00; step(6);
      keys = 2'b11; step(6);
    end
    chk("sat_drop", {24'd0, drops}, 255);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire
